// File: rtl/aes_round_sequencer_if.sv
// Block source/sink handshake plus round-datapath and key-store connections
// for the iterative AES round sequencer.
interface aes_round_sequencer_if #(
  parameter int KIDX_W = 4
);
  logic              key_ready;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [127:0]      in_block;
  logic [127:0]      dp_state;
  logic [2:0]        dp_op;
  logic [KIDX_W-1:0] key_idx;
  logic [127:0]      dp_result;
  logic              out_valid;
  logic              out_ready;
  logic [127:0]      out_block;
  logic              busy;
  logic [KIDX_W-1:0] round;

  modport master (
    input  key_ready, in_valid, in_mode, in_block, dp_result, out_ready,
    output in_ready, dp_state, dp_op, key_idx, out_valid, out_block, busy, round
  );

  modport slave (
    output key_ready, in_valid, in_mode, in_block, dp_result, out_ready,
    input  in_ready, dp_state, dp_op, key_idx, out_valid, out_block, busy, round
  );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES-128 controller: walks one shared round datapath through the
// cipher or inverse cipher, one operation per clock, holding the 128-bit state.
module aes_round_sequencer #(
  parameter int NR     = 10,
  parameter int KIDX_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  aes_round_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_INIT  = 3'd1,
    ST_ROUND = 3'd2,
    ST_FINAL = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADDKEY   = 3'd0;
  localparam logic [2:0] OP_ENC_RND  = 3'd1;
  localparam logic [2:0] OP_ENC_LAST = 3'd2;
  localparam logic [2:0] OP_DEC_RND  = 3'd3;
  localparam logic [2:0] OP_DEC_LAST = 3'd4;
  localparam logic [2:0] OP_NOP      = 3'd7;

  localparam logic [KIDX_W-1:0] KEY_ZERO   = {KIDX_W{1'b0}};
  localparam logic [KIDX_W-1:0] KEY_LAST   = KIDX_W'(NR);
  localparam logic [KIDX_W-1:0] RND_ONE    = KIDX_W'(1);
  localparam logic [KIDX_W-1:0] RND_PENULT = KIDX_W'(NR - 1);

  state_t            state_r, state_s;
  logic [127:0]      data_r, data_s;
  logic              mode_r, mode_s;
  logic [KIDX_W-1:0] round_r, round_s;
  logic [2:0]        op_r, op_s;
  logic [KIDX_W-1:0] kidx_r, kidx_s;
  logic              idle_r, idle_s;
  logic              busy_r, busy_s;
  logic              out_valid_r, out_valid_s;
  logic              accept_s;

  // Next FSM state, round counter and state-register capture
  always_comb begin
    state_s  = state_r;
    data_s   = data_r;
    mode_s   = mode_r;
    round_s  = round_r;
    accept_s = idle_r & bus.key_ready & bus.in_valid;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          data_s  = bus.in_block;
          mode_s  = bus.in_mode;
          state_s = ST_INIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_INIT: begin
        data_s  = bus.dp_result;
        round_s = RND_ONE;
        state_s = ST_ROUND;
      end
      ST_ROUND: begin
        data_s = bus.dp_result;
        if (round_r == RND_PENULT) begin
          round_s = KEY_LAST;
          state_s = ST_FINAL;
        end else begin
          round_s = round_r + RND_ONE;
        end
      end
      ST_FINAL: begin
        data_s  = bus.dp_result;
        state_s = ST_DONE;
      end
      ST_DONE: begin
        if (bus.out_ready) begin
          round_s = KEY_ZERO;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: begin
        round_s = KEY_ZERO;
        state_s = ST_IDLE;
      end
    endcase
  end

  // Decode next-cycle outputs so operation select and key index are registered
  always_comb begin
    op_s        = OP_NOP;
    kidx_s      = KEY_ZERO;
    idle_s      = 1'b0;
    busy_s      = 1'b0;
    out_valid_s = 1'b0;
    case (state_s)
      ST_IDLE: idle_s = 1'b1;
      ST_INIT: begin
        busy_s = 1'b1;
        op_s   = OP_ADDKEY;
        kidx_s = mode_s ? KEY_LAST : KEY_ZERO;
      end
      ST_ROUND: begin
        busy_s = 1'b1;
        op_s   = mode_s ? OP_DEC_RND : OP_ENC_RND;
        kidx_s = mode_s ? (KEY_LAST - round_s) : round_s;
      end
      ST_FINAL: begin
        busy_s = 1'b1;
        op_s   = mode_s ? OP_DEC_LAST : OP_ENC_LAST;
        kidx_s = mode_s ? KEY_ZERO : KEY_LAST;
      end
      ST_DONE: out_valid_s = 1'b1;
      default: idle_s = 1'b0;
    endcase
  end

  // State and output registers; reset aborts any block in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      data_r      <= 128'd0;
      mode_r      <= 1'b0;
      round_r     <= KEY_ZERO;
      op_r        <= OP_NOP;
      kidx_r      <= KEY_ZERO;
      idle_r      <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      data_r      <= data_s;
      mode_r      <= mode_s;
      round_r     <= round_s;
      op_r        <= op_s;
      kidx_r      <= kidx_s;
      idle_r      <= idle_s;
      busy_r      <= busy_s;
      out_valid_r <= out_valid_s;
    end
  end

  // in_ready follows key_ready directly while idle so a late key store costs no cycle
  assign bus.in_ready  = idle_r & bus.key_ready;
  assign bus.dp_state  = data_r;
  assign bus.out_block = data_r;
  assign bus.dp_op     = op_r;
  assign bus.key_idx   = kidx_r;
  assign bus.out_valid = out_valid_r;
  assign bus.busy      = busy_r;
  assign bus.round     = round_r;

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Self-checking bench: behavioural AES round datapath/key store around the
// sequencer, with a whole-cipher reference for expected results.
module tb_aes_round_sequencer;
  localparam int NR = 10;

  logic clk = 1'b0;
  logic rst;
  int   total  = 0;
  int   passed = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk       [16];

  aes_round_sequencer_if #(.KIDX_W(4)) bus ();
  aes_round_sequencer #(.NR(NR), .KIDX_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "timeout");
  end

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = inv ? inv_sbox[gb(s, i)] : sbox[gb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = inv ? gb(s, r + 4*((c + 4 - r) % 4)) : gb(s, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix_cols(input logic [127:0] s, input bit inv);
    logic [127:0] o;
    logic [7:0] a [4];
    logic [7:0] k0, k1, k2, k3;
    k0 = inv ? 8'd14 : 8'd2;  k1 = inv ? 8'd11 : 8'd3;
    k2 = inv ? 8'd13 : 8'd1;  k3 = inv ? 8'd9  : 8'd1;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) a[r] = gb(s, r + 4*c);
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gmul(a[r], k0) ^ gmul(a[(r+1)%4], k1) ^
                                gmul(a[(r+2)%4], k2) ^ gmul(a[(r+3)%4], k3);
    end
    return o;
  endfunction

  // Round datapath as the sequencer sees it
  function automatic logic [127:0] dp_model(input logic [127:0] s, input logic [2:0] op,
                                            input logic [127:0] k);
    case (op)
      3'd0:    return s ^ k;
      3'd1:    return mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ k;
      3'd2:    return shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ k;
      3'd3:    return mix_cols(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k, 1'b1);
      3'd4:    return sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ k;
      default: return s;
    endcase
  endfunction

  assign bus.dp_result = dp_model(bus.dp_state, bus.dp_op, rk[bus.key_idx]);

  // Whole-block reference: FIPS-197 cipher / inverse cipher
  function automatic logic [127:0] aes_ref(input logic [127:0] blk, input logic mode);
    logic [127:0] s;
    if (!mode) begin
      s = blk ^ rk[0];
      for (int r = 1; r < NR; r++) s = mix_cols(shift_rows(sub_bytes(s, 1'b0), 1'b0), 1'b0) ^ rk[r];
      s = shift_rows(sub_bytes(s, 1'b0), 1'b0) ^ rk[NR];
    end else begin
      s = blk ^ rk[NR];
      for (int r = NR - 1; r >= 1; r--) s = mix_cols(sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[r], 1'b1);
      s = sub_bytes(shift_rows(s, 1'b1), 1'b1) ^ rk[0];
    end
    return s;
  endfunction

  task automatic build_sbox();
    logic [7:0] inv, y;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, 8'(x));
      y = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x]     = y;
      inv_sbox[y] = 8'(x);
    end
  endtask

  task automatic set_key(input logic [127:0] key);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rcon = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rcon, 24'h000000};
        rcon = gmul(rcon, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 16; r++) rk[r] = (r <= NR) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : 128'd0;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called just after a falling edge with the sequencer idle; returns likewise
  task automatic run_block(input logic [127:0] blk, input logic mode, input logic [127:0] expv,
                           input int hold, input bit poke);
    int n = 0;
    logic [2:0] eop;
    logic [3:0] ekey;
    bus.in_valid  = 1'b1;
    bus.in_block  = blk;
    bus.in_mode   = mode;
    bus.out_ready = (hold == 0);
    #1;
    while (bus.in_ready !== 1'b1 && n < 40) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_wait", {127'd0, bus.in_ready}, 128'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_mode  = ~mode;
    bus.in_block = rnd128();
    for (int k = 0; k <= NR; k++) begin
      if (k == 0) begin
        eop = 3'd0;                  ekey = mode ? 4'(NR) : 4'd0;
      end else if (k < NR) begin
        eop = mode ? 3'd3 : 3'd1;    ekey = mode ? 4'(NR - k) : 4'(k);
      end else begin
        eop = mode ? 3'd4 : 3'd2;    ekey = mode ? 4'd0 : 4'(NR);
      end
      chk($sformatf("seq_k%0d", k),
          {114'd0, bus.busy, bus.in_ready, bus.out_valid, bus.dp_op, bus.key_idx, bus.round},
          {114'd0, 1'b1, 1'b0, 1'b0, eop, ekey, 4'(k)});
      if (poke && k == 3) begin
        bus.in_valid = 1'b1; bus.in_block = rnd128();
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
    end
    for (int h = 0; h <= hold; h++) begin
      chk("done_ctl", {114'd0, bus.out_valid, bus.busy, bus.in_ready, bus.dp_op, bus.key_idx, bus.round},
          {114'd0, 1'b1, 1'b0, 1'b0, 3'd7, 4'd0, 4'(NR)});
      chk("out_block", bus.out_block, expv);
      if (h == hold) bus.out_ready = 1'b1;
      @(negedge clk);
    end
    chk("back_idle", {118'd0, bus.out_valid, bus.busy, bus.dp_op, bus.round},
        {118'd0, 1'b0, 1'b0, 3'd7, 4'd0});
  endtask

  initial begin
    logic [127:0] pt, ct, blk;
    logic         m;
    rst = 1'b1;
    bus.key_ready = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_block  = 128'd0;
    bus.out_ready = 1'b0;
    build_sbox();
    set_key(128'h000102030405060708090a0b0c0d0e0f);
    pt = 128'h00112233445566778899aabbccddeeff;
    ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    repeat (3) @(negedge clk);
    chk("reset_ctl", {114'd0, bus.in_ready, bus.out_valid, bus.busy, bus.dp_op, bus.key_idx, bus.round},
        {114'd0, 1'b0, 1'b0, 1'b0, 3'd7, 4'd0, 4'd0});
    chk("reset_state", bus.dp_state, 128'd0);
    rst = 1'b0;
    @(negedge clk);

    run_block(pt, 1'b0, ct, 0, 1'b0);
    run_block(ct, 1'b1, pt, 0, 1'b0);
    blk = rnd128();
    run_block(blk, 1'b0, aes_ref(blk, 1'b0), 5, 1'b0);

    // key store not ready: request must wait
    bus.key_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_block  = pt;
    repeat (3) begin
      @(negedge clk);
      chk("key_wait", {126'd0, bus.in_ready, bus.busy}, 128'd0);
    end
    bus.key_ready = 1'b1;
    run_block(pt, 1'b0, ct, 0, 1'b0);

    blk = rnd128();
    m   = 1'($urandom_range(0, 1));
    run_block(blk, m, aes_ref(blk, m), 0, 1'b1);

    // abort mid-block with reset
    bus.in_valid = 1'b1; bus.in_block = rnd128(); bus.in_mode = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_abort_round", {124'd0, bus.round}, 128'd5);
    rst = 1'b1;
    #1;
    chk("abort_ctl", {114'd0, bus.in_ready, bus.out_valid, bus.busy, bus.dp_op, bus.key_idx, bus.round},
        {114'd0, 1'b0, 1'b0, 1'b0, 3'd7, 4'd0, 4'd0});
    chk("abort_state", bus.out_block, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    run_block(pt, 1'b0, ct, 0, 1'b0);

    set_key(rnd128());
    for (int t = 0; t < 6; t++) begin
      blk = rnd128();
      m   = 1'($urandom_range(0, 1));
      run_block(blk, m, aes_ref(blk, m), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
